// File: rtl/bus_fifo_port.sv
// bus_fifo_port: CPU register port bridging a 32-bit bus to a TX stream and an RX stream via two FIFOs.
// Latency: a word pushed at edge N is visible at the FIFO head (tx_data / RXDATA) after edge N; bus reads are zero-wait.
// Backpressure: tx_valid = TX not empty and pops on tx_ready; rx_ready = RX not full. Bus writes to a full TX are dropped (tx_ovf).
//
// Ports:
//   clk, rst                  single clock, asynchronous active-low reset
//   addr, cs, wr_rd           CPU bus; addr[3:2] selects TXDATA/RXDATA/STATUS/CTRL
//   data_bus_write            CPU write data
//   data_bus_read             CPU read data, combinational, 0 unless a read is selected
//   tx_data/tx_valid/tx_ready outbound stream (TX FIFO head)
//   rx_data/rx_valid/rx_ready inbound stream (into RX FIFO)

// bus_fifo_port_fifo: circular DEPTH x W FIFO with gated push/pop and synchronous flush.
// Latency: pushed word reaches the head one edge later; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty, both ignored during flush.
module bus_fifo_port_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [4:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = 5'(count_q);

    // Full/empty are judged on the state before the edge, so a pop in the
    // same cycle never makes room for a push and a push never feeds a pop.
    assign push_ok = push_i && !full_o  && !flush_i;
    assign pop_ok  = pop_i  && !empty_o && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; flush and reset only move the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end
endmodule

module bus_fifo_port #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        cs,
    input  logic        wr_rd,
    input  logic [31:0] data_bus_write,
    output logic [31:0] data_bus_read,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    logic [1:0]  reg_sel;
    logic        bus_wr;
    logic        bus_rd;
    logic        ctrl_wr;

    logic        tx_push, tx_pop, tx_flush;
    logic        tx_full, tx_empty;
    logic [4:0]  tx_count;
    logic [31:0] tx_head;

    logic        rx_push, rx_pop, rx_flush;
    logic        rx_full, rx_empty;
    logic [4:0]  rx_count;
    logic [31:0] rx_head;

    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_udf_q, rx_udf_d;
    logic [31:0] status;

    // Only addr[3:2] is decoded; the rest of the bus is intentionally ignored.
    logic        unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], data_bus_write[31:6],
                           data_bus_write[3:2], tx_count[4], rx_count[4]};

    assign reg_sel = addr[3:2];
    assign bus_wr  = cs && wr_rd;
    assign bus_rd  = cs && !wr_rd;
    assign ctrl_wr = bus_wr && (reg_sel == REG_CTRL);

    assign tx_push  = bus_wr && (reg_sel == REG_TXDATA);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_flush = ctrl_wr && data_bus_write[0];

    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = bus_rd && (reg_sel == REG_RXDATA);
    assign rx_flush = ctrl_wr && data_bus_write[1];

    bus_fifo_port_fifo #(.DEPTH(DEPTH), .W(32)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .flush_i (tx_flush),
        .wdata_i (data_bus_write),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    bus_fifo_port_fifo #(.DEPTH(DEPTH), .W(32)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .flush_i (rx_flush),
        .wdata_i (rx_data),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_head;
    assign rx_ready = !rx_full;

    // Sticky error flags; a CTRL clear wins over a same-cycle set.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;
        if (ctrl_wr && data_bus_write[4]) begin
            tx_ovf_d = 1'b0;
        end else if (tx_push && tx_full) begin
            tx_ovf_d = 1'b1;
        end
        if (ctrl_wr && data_bus_write[5]) begin
            rx_udf_d = 1'b0;
        end else if (rx_pop && rx_empty) begin
            rx_udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    // Count fields are 4 bits wide; at DEPTH=16 a full FIFO reads as count 0
    // with the full bit set.
    assign status = {18'b0, rx_udf_q, tx_ovf_q, rx_count[3:0], tx_count[3:0],
                     rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        data_bus_read = 32'h0;
        if (bus_rd) begin
            case (reg_sel)
                REG_RXDATA: data_bus_read = rx_empty ? 32'h0 : rx_head;
                REG_STATUS: data_bus_read = status;
                default:    data_bus_read = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_fifo_port.sv
module tb_bus_fifo_port;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_TX = 32'h0, A_RX = 32'h4, A_ST = 32'h8, A_CT = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        cs;
    logic        wr_rd;
    logic [31:0] data_bus_write;
    logic [31:0] data_bus_read;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    bus_fifo_port #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .cs             (cs),
        .wr_rd          (wr_rd),
        .data_bus_write (data_bus_write),
        .data_bus_read  (data_bus_read),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the two FIFOs as queues plus the sticky flags.
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    bit          m_ovf;
    bit          m_udf;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        tr;
        logic        rv;
        logic [31:0] rxd;
        logic [31:0] exp_rd;
        logic        exp_v;
        logic [31:0] exp_td;
        logic        exp_rr;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {18'b0, m_udf, m_ovf, 4'(rxq.size()), 4'(txq.size()),
                rxq.size() == 0, rxq.size() == DEPTH, txq.size() == 0, txq.size() == DEPTH};
    endfunction

    function automatic logic [31:0] m_read();
        if (!cs || wr_rd) return 32'h0;
        case (addr[3:2])
            2'd1:    return (rxq.size() != 0) ? rxq[0] : 32'h0;
            2'd2:    return m_status();
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_model(input string tag);
        chk($sformatf("%s.rd", tag), data_bus_read, m_read());
        chk($sformatf("%s.tx_valid", tag), {31'b0, tx_valid}, {31'b0, txq.size() != 0});
        if (txq.size() != 0) chk($sformatf("%s.tx_data", tag), tx_data, txq[0]);
        chk($sformatf("%s.rx_ready", tag), {31'b0, rx_ready}, {31'b0, rxq.size() != DEPTH});
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [1:0] r;
        bit bw, br, ctl;
        int ts, rs;
        bit tx_push, tx_pop, tx_fl, ovf_set, rx_push, rx_pop, rx_fl, udf_set;
        r   = addr[3:2];
        bw  = cs && wr_rd;
        br  = cs && !wr_rd;
        ctl = bw && (r == 2'd3);
        ts  = txq.size();
        rs  = rxq.size();
        tx_push = bw && (r == 2'd0) && (ts < DEPTH);
        ovf_set = bw && (r == 2'd0) && (ts == DEPTH);
        tx_pop  = (ts > 0) && tx_ready;
        tx_fl   = ctl && data_bus_write[0];
        rx_push = rx_valid && (rs < DEPTH);
        rx_pop  = br && (r == 2'd1) && (rs > 0);
        udf_set = br && (r == 2'd1) && (rs == 0);
        rx_fl   = ctl && data_bus_write[1];
        if (tx_fl) txq.delete();
        else begin
            if (tx_pop)  void'(txq.pop_front());
            if (tx_push) txq.push_back(data_bus_write);
        end
        if (rx_fl) rxq.delete();
        else begin
            if (rx_pop)  void'(rxq.pop_front());
            if (rx_push) rxq.push_back(rx_data);
        end
        if (ctl && data_bus_write[4]) m_ovf = 1'b0;
        else if (ovf_set)             m_ovf = 1'b1;
        if (ctl && data_bus_write[5]) m_udf = 1'b0;
        else if (udf_set)             m_udf = 1'b1;
    endtask

    task automatic set_in(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic tr, input logic rv, input logic [31:0] rd);
        cs = c; wr_rd = w; addr = a; data_bus_write = d;
        tx_ready = tr; rx_valid = rv; rx_data = rd;
    endtask

    task automatic step(input string tag);
        #1;
        check_model(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step_exp(input string tag, input logic [31:0] exp_rd);
        #1;
        chk(tag, data_bus_read, exp_rd);
        check_model(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset off-edge and checks the reset view before any clock edge.
    task automatic do_reset();
        rst = 1'b0;
        txq.delete();
        rxq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        cs = 1'b1; wr_rd = 1'b0; addr = A_ST;
        #1;
        chk("reset.status", data_bus_read, 32'h0000000A);
        chk("reset.tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("reset.rx_ready", {31'b0, rx_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cs wr addr wd tr rv rxd | exp_rd exp_v exp_td exp_rr
        vt[0]  = '{1, 0, A_ST, 0,     0, 0, 0,            32'h0000000A, 0, 0,     1};
        vt[1]  = '{1, 1, A_TX, 32'h11, 0, 0, 0,           32'h0,        0, 0,     1};
        vt[2]  = '{1, 1, A_TX, 32'h22, 0, 0, 0,           32'h0,        1, 32'h11, 1};
        vt[3]  = '{1, 1, A_TX, 32'h33, 0, 0, 0,           32'h0,        1, 32'h11, 1};
        vt[4]  = '{1, 0, A_ST, 0,     0, 0, 0,            32'h00000038, 1, 32'h11, 1};
        vt[5]  = '{0, 0, 0,    0,     1, 0, 0,            32'h0,        1, 32'h11, 1};
        vt[6]  = '{0, 0, 0,    0,     1, 0, 0,            32'h0,        1, 32'h22, 1};
        vt[7]  = '{0, 0, 0,    0,     1, 0, 0,            32'h0,        1, 32'h33, 1};
        vt[8]  = '{0, 0, 0,    0,     1, 0, 0,            32'h0,        0, 0,     1};
        vt[9]  = '{0, 0, 0,    0,     0, 1, 32'hA5A5A5A5, 32'h0,        0, 0,     1};
        vt[10] = '{0, 0, 0,    0,     0, 1, 32'h5A5A5A5A, 32'h0,        0, 0,     1};
        vt[11] = '{1, 0, A_RX, 0,     0, 0, 0,            32'hA5A5A5A5, 0, 0,     1};
        vt[12] = '{1, 0, A_RX, 0,     0, 0, 0,            32'h5A5A5A5A, 0, 0,     1};
        vt[13] = '{1, 0, A_RX, 0,     0, 0, 0,            32'h0,        0, 0,     1};
        vt[14] = '{1, 0, A_ST, 0,     0, 0, 0,            32'h0000200A, 0, 0,     1};
        vt[15] = '{1, 1, A_CT, 32'h20, 0, 0, 0,           32'h0,        0, 0,     1};
        vt[16] = '{1, 0, A_ST, 0,     0, 0, 0,            32'h0000000A, 0, 0,     1};

        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        do_reset();

        // Directed table: TX ordering, RX ordering, underflow and its clear.
        for (int i = 0; i < 17; i++) begin
            set_in(vt[i].cs, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].tr, vt[i].rv, vt[i].rxd);
            #1;
            chk($sformatf("vec%0d.rd", i), data_bus_read, vt[i].exp_rd);
            chk($sformatf("vec%0d.tx_valid", i), {31'b0, tx_valid}, {31'b0, vt[i].exp_v});
            if (vt[i].exp_v) chk($sformatf("vec%0d.tx_data", i), tx_data, vt[i].exp_td);
            chk($sformatf("vec%0d.rx_ready", i), {31'b0, rx_ready}, {31'b0, vt[i].exp_rr});
            model_edge();
            @(posedge clk);
            #1;
        end

        // Overflow: DEPTH+1 writes with the sink stalled; the last is dropped.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            set_in(1, 1, A_TX, 32'(i), 0, 0, 0);
            step("ovf.wr");
        end
        set_in(1, 0, A_ST, 0, 0, 0, 0);
        step_exp("ovf.status", 32'h00001089);
        set_in(1, 1, A_CT, 32'h10, 0, 0, 0);
        step("ovf.clr");
        set_in(1, 0, A_ST, 0, 0, 0, 0);
        step_exp("ovf.cleared", 32'h00000089);
        for (int i = 1; i <= DEPTH; i++) begin
            set_in(0, 0, 0, 0, 1, 0, 0);
            #1;
            chk("ovf.drain", tx_data, 32'(i));
            step("ovf.drain_m");
        end
        #1;
        chk("ovf.empty", {31'b0, tx_valid}, 32'h0);

        // Full TX with a pop and a write in the same cycle: write is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, A_TX, 32'h100 + 32'(i), 0, 0, 0);
            step("same.fill");
        end
        set_in(1, 1, A_TX, 32'h0000DEAD, 1, 0, 0);
        step("same.wr_pop");
        set_in(1, 0, A_ST, 0, 0, 0, 0);
        step_exp("same.status", 32'h00001078);
        set_in(1, 1, A_CT, 32'h11, 0, 0, 0);
        step("same.flush");
        set_in(1, 0, A_ST, 0, 0, 0, 0);
        step_exp("same.flushed", 32'h0000000A);

        // RX flush wins over a same-cycle push, then reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 32'hC0 + 32'(i));
            step("rxfl.push");
        end
        set_in(1, 0, A_ST, 0, 0, 0, 0);
        step_exp("rxfl.three", 32'h00000302);
        set_in(1, 1, A_CT, 32'h2, 0, 1, 32'h00000BAD);
        step("rxfl.flush");
        set_in(1, 0, A_ST, 0, 0, 0, 0);
        step_exp("rxfl.empty", 32'h0000000A);
        set_in(1, 1, A_TX, 32'h77, 0, 1, 32'hE1);
        step("rst.pre1");
        set_in(0, 0, 0, 0, 0, 1, 32'hE2);
        step("rst.pre2");
        #3;
        do_reset();
        set_in(1, 0, A_ST, 0, 0, 0, 0);
        step_exp("rst.after", 32'h0000000A);

        // Randomised traffic against the model, with phases biased toward full/empty.
        for (int p = 0; p < 12; p++) begin
            int tr_pct, rv_pct;
            tr_pct = (p % 3 == 0) ? 10 : ((p % 3 == 1) ? 90 : 50);
            rv_pct = (p % 4 == 0) ? 90 : ((p % 4 == 1) ? 10 : 50);
            for (int c = 0; c < 200; c++) begin
                int k;
                logic [31:0] a;
                logic [1:0] sel;
                k = $urandom_range(0, 15);
                sel = (k < 6) ? 2'd0 : (k < 11) ? 2'd1 : (k < 14) ? 2'd2 : 2'd3;
                a = $urandom;
                a[3:2] = sel;
                set_in($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, a, $urandom,
                       $urandom_range(0, 99) < tr_pct, $urandom_range(0, 99) < rv_pct, $urandom);
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
